// File: rtl/mux_nx1_scanner.sv
// N_CH:1 mux with manual select or dwell-timed channel scan; optional MUX_SCAN_CH_MASK_EN adds ch_mask.
// Manual: 1-cycle latency. Scan: out_valid dwell+1 edges after start, then held until out_ready.
module mux_nx1_scanner #(
  parameter int N_CH    = 8,
  parameter int W       = 1,
  parameter int DWELL_W = 8,
  localparam int SEL_W  = $clog2(N_CH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_CH*W-1:0]    din,
  input  logic [SEL_W-1:0]     sel,
  input  logic                 mode,
  input  logic                 start,
  input  logic [DWELL_W-1:0]   dwell,
  output logic [W-1:0]         dout,
  output logic [SEL_W-1:0]     ch,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 wrap
`ifdef MUX_SCAN_CH_MASK_EN
  ,
  input  logic [N_CH-1:0]      ch_mask
`endif
);

  typedef enum logic [1:0] {IDLE, SCAN, WAIT} state_t;

  state_t               state, state_n;
  logic [SEL_W-1:0]     idx, idx_n, ch_n;
  logic [SEL_W-1:0]     first_ch, next_ch;
  logic                 next_found;
  logic [DWELL_W-1:0]   dwell_cnt, cnt_n;
  logic [W-1:0]         dout_n;
  logic                 ov_n, wrap_n;
  logic [N_CH-1:0]      en;
  logic                 any_en;

`ifdef MUX_SCAN_CH_MASK_EN
  assign en = ch_mask;
`else
  assign en = '1;
`endif
  assign any_en = |en;
  assign busy   = (state != IDLE);

  // Out-of-range selects fall through to zero.
  function automatic logic [W-1:0] pick(input logic [N_CH*W-1:0] d, input logic [SEL_W-1:0] s);
    logic [W-1:0] r;
    r = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (int'(s) == k) r = d[k*W +: W];
    end
    return r;
  endfunction

  always_comb begin
    first_ch = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (en[k]) first_ch = SEL_W'(k);
    end
  end

  // Lowest enabled channel above idx, else wrap around to the lowest enabled one.
  always_comb begin
    next_ch    = first_ch;
    next_found = 1'b0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (en[k] && (k > int'(idx))) begin
        next_ch    = SEL_W'(k);
        next_found = 1'b1;
      end
    end
    if (!next_found) next_ch = first_ch;
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    cnt_n   = dwell_cnt;
    dout_n  = dout;
    ch_n    = ch;
    ov_n    = out_valid;
    wrap_n  = 1'b0;
    case (state)
      IDLE: begin
        ov_n = 1'b0;
        if (!mode) begin
          dout_n = pick(din, sel);
          ch_n   = sel;
        end else if (start && any_en) begin
          state_n = SCAN;
          idx_n   = first_ch;
          cnt_n   = dwell;
        end
      end
      SCAN: begin
        if (!mode) begin
          state_n = IDLE;
        end else if (dwell_cnt != '0) begin
          cnt_n = dwell_cnt - 1'b1;
        end else begin
          dout_n  = pick(din, idx);
          ch_n    = idx;
          ov_n    = 1'b1;
          state_n = WAIT;
        end
      end
      WAIT: begin
        // A pending sample always finishes its handshake before leaving the scan.
        if (out_ready) begin
          ov_n = 1'b0;
          if (!mode || !any_en) begin
            state_n = IDLE;
          end else begin
            idx_n   = next_ch;
            wrap_n  = (next_ch <= idx);
            cnt_n   = dwell;
            state_n = SCAN;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      dwell_cnt <= '0;
      dout      <= '0;
      ch        <= '0;
      out_valid <= 1'b0;
      wrap      <= 1'b0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      dwell_cnt <= cnt_n;
      dout      <= dout_n;
      ch        <= ch_n;
      out_valid <= ov_n;
      wrap      <= wrap_n;
    end
  end

endmodule

// File: tb/tb_mux_nx1_scanner.sv
// Directed-vector bench for mux_nx1_scanner (N_CH=8, W=1, DWELL_W=8).
module tb_mux_nx1_scanner;

  logic       clk;
  logic       rst;
  logic [7:0] din;
  logic [2:0] sel;
  logic       mode;
  logic       start;
  logic [7:0] dwell;
  logic [0:0] dout;
  logic [2:0] ch;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic       wrap;
`ifdef MUX_SCAN_CH_MASK_EN
  logic [7:0] ch_mask;
`endif

  int n_vec = 0;
  int n_err = 0;

  mux_nx1_scanner #(.N_CH(8), .W(1), .DWELL_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .sel       (sel),
    .mode      (mode),
    .start     (start),
    .dwell     (dwell),
    .dout      (dout),
    .ch        (ch),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .wrap      (wrap)
`ifdef MUX_SCAN_CH_MASK_EN
    ,
    .ch_mask   (ch_mask)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_man [8] = '{1, 1, 1, 0, 0, 1, 0, 1};
    int exp_ch  [4] = '{0, 2, 6, 0};
    int exp_wr  [4] = '{0, 0, 1, 0};
    int wraps;

    rst = 1'b1; din = 8'b10100111; sel = 3'd0; mode = 1'b0; start = 1'b0;
    dwell = 8'd0; out_ready = 1'b0;
`ifdef MUX_SCAN_CH_MASK_EN
    ch_mask = 8'hFF;
`endif
    tick(); tick();
    check_eq("rst_dout", 32'(dout), 0);
    check_eq("rst_ch", 32'(ch), 0);
    check_eq("rst_valid", 32'(out_valid), 0);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_wrap", 32'(wrap), 0);

    // Manual select sweep
    rst = 1'b0;
    for (int s = 0; s < 8; s++) begin
      sel = 3'(s);
      tick();
      check_eq("man_dout", 32'(dout), 32'(exp_man[s]));
      check_eq("man_ch", 32'(ch), 32'(s));
      check_eq("man_valid", 32'(out_valid), 0);
    end

    // Full scan, dwell 0, consumer always ready
    mode = 1'b1; dwell = 8'd0; out_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("scan_busy", 32'(busy), 1);
    check_eq("scan_start_valid", 32'(out_valid), 0);
    wraps = 0;
    for (int i = 0; i < 9; i++) begin
      tick();
      check_eq("scan_valid_hi", 32'(out_valid), 1);
      check_eq("scan_ch", 32'(ch), 32'(i % 8));
      check_eq("scan_dout", 32'(dout), 32'(exp_man[i % 8]));
      check_eq("scan_wrap_cap", 32'(wrap), 0);
      tick();
      check_eq("scan_valid_lo", 32'(out_valid), 0);
      check_eq("scan_wrap", 32'(wrap), (i == 7) ? 32'd1 : 32'd0);
      if (wrap) wraps++;
    end
    check_eq("scan_wrap_count", 32'(wraps), 1);

    // Mode drop while in SCAN
    mode = 1'b0; out_ready = 1'b0;
    tick();
    check_eq("drop_scan_busy", 32'(busy), 0);
    check_eq("drop_scan_valid", 32'(out_valid), 0);

    // dwell=3 latency and backpressure hold
    mode = 1'b1; dwell = 8'd3; out_ready = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("dwell_valid_lo", 32'(out_valid), 0);
    end
    tick();
    check_eq("dwell_valid_hi", 32'(out_valid), 1);
    check_eq("dwell_ch", 32'(ch), 0);
    check_eq("dwell_dout", 32'(dout), 1);
    din = 8'h00;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("hold_valid", 32'(out_valid), 1);
      check_eq("hold_ch", 32'(ch), 0);
      check_eq("hold_dout", 32'(dout), 1);
      check_eq("hold_busy", 32'(busy), 1);
    end
    dwell = 8'd1; out_ready = 1'b1;
    tick();
    check_eq("hs_valid", 32'(out_valid), 0);
    check_eq("hs_wrap", 32'(wrap), 0);
    out_ready = 1'b0; din = 8'b10100111;
    tick();
    check_eq("redwell_valid_lo", 32'(out_valid), 0);
    tick();
    check_eq("redwell_valid_hi", 32'(out_valid), 1);
    check_eq("redwell_ch", 32'(ch), 1);
    check_eq("redwell_dout", 32'(dout), 1);

    // Mode drop while in WAIT: handshake first
    mode = 1'b0;
    tick();
    check_eq("drop_wait_valid", 32'(out_valid), 1);
    check_eq("drop_wait_busy", 32'(busy), 1);
    out_ready = 1'b1;
    tick();
    check_eq("drop_wait_done_valid", 32'(out_valid), 0);
    check_eq("drop_wait_done_busy", 32'(busy), 0);
    check_eq("drop_wait_done_wrap", 32'(wrap), 0);
    check_eq("drop_wait_done_ch", 32'(ch), 1);

    // Reset during WAIT
    mode = 1'b1; dwell = 8'd0; out_ready = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check_eq("pre_rst_ch0", 32'(ch), 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick();
    check_eq("pre_rst_ch1", 32'(ch), 1);
    check_eq("pre_rst_valid", 32'(out_valid), 1);
    rst = 1'b1;
    tick();
    check_eq("wrst_dout", 32'(dout), 0);
    check_eq("wrst_ch", 32'(ch), 0);
    check_eq("wrst_valid", 32'(out_valid), 0);
    check_eq("wrst_busy", 32'(busy), 0);
    check_eq("wrst_wrap", 32'(wrap), 0);
    rst = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check_eq("restart_valid", 32'(out_valid), 1);
    check_eq("restart_ch", 32'(ch), 0);
    out_ready = 1'b1; mode = 1'b0;
    tick();
    check_eq("restart_idle", 32'(busy), 0);

`ifdef MUX_SCAN_CH_MASK_EN
    // Masked scan over channels 0, 2, 6
    mode = 1'b1; dwell = 8'd0; out_ready = 1'b1; ch_mask = 8'b01000101; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("mask_valid", 32'(out_valid), 1);
      check_eq("mask_ch", 32'(ch), 32'(exp_ch[i]));
      tick();
      check_eq("mask_wrap", 32'(wrap), 32'(exp_wr[i]));
    end
    mode = 1'b0;
    tick();
    ch_mask = 8'h00; mode = 1'b1; start = 1'b1;
    tick();
    check_eq("mask0_busy_a", 32'(busy), 0);
    tick();
    check_eq("mask0_busy_b", 32'(busy), 0);
    start = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
